// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Runs a display raster (hc, vc) and a request raster (rhc, rvc) that sits
// LOOKAHEAD pixel ticks ahead of it. Both advance only on EN pixel ticks.
// All outputs are registered decodes of the counter state, one CLK behind it.
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   EN               pixel tick enable
//   VGA_HS, VGA_VS   syncs, active level HS_POL / VS_POL
//   VGA_BLANK        1 = visible pixel
//   VGA_SYNC         sync-on-green, tied low
//   X, Y             visible display coordinate (0 outside visible area)
//   REQ, REQ_X/Y     look-ahead pixel request and its coordinate
//   LINE_START       one-CLK strobe after each horizontal wrap
//   FRAME_START      one-CLK strobe after each frame wrap
module vga_timing_gen #(
    parameter int unsigned H_DISP    = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_PULSE   = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISP    = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_PULSE   = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned HS_POL    = 0,
    parameter int unsigned VS_POL    = 0,
    parameter int unsigned LOOKAHEAD = 2,
    localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_PULSE + H_BP,
    localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_PULSE + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK,
    output logic          VGA_SYNC,
    output logic [HW-1:0] X,
    output logic [VW-1:0] Y,
    output logic          REQ,
    output logic [HW-1:0] REQ_X,
    output logic [VW-1:0] REQ_Y,
    output logic          LINE_START,
    output logic          FRAME_START
);

    localparam int unsigned HS_START = H_DISP + H_FP;
    localparam int unsigned HS_END   = H_DISP + H_FP + H_PULSE;
    localparam int unsigned VS_START = V_DISP + V_FP;
    localparam int unsigned VS_END   = V_DISP + V_FP + V_PULSE;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] RH_INIT = HW'(LOOKAHEAD);
    localparam logic          HS_ACT  = 1'(HS_POL);
    localparam logic          VS_ACT  = 1'(VS_POL);

    // Reject degenerate timings at elaboration
    if (H_DISP == 0 || H_PULSE == 0 || V_DISP == 0 || V_PULSE == 0) begin : g_bad_timing
        $error("vga_timing_gen: DISP and PULSE parameters must be non-zero");
    end
    if (LOOKAHEAD >= H_TOTAL) begin : g_bad_lookahead
        $error("vga_timing_gen: LOOKAHEAD must be less than H_TOTAL");
    end

    logic [HW-1:0] hc, rhc;
    logic [VW-1:0] vc, rvc;
    logic          h_wrap, v_wrap, rh_wrap, rv_wrap;
    logic          line_wrap_q, frame_wrap_q;
    logic          hs_act, vs_act, vis, rvis;

    assign VGA_SYNC = 1'b0;

    // Wrap and window decodes of the current counter state
    always_comb begin
        h_wrap  = (hc == H_LAST);
        v_wrap  = (vc == V_LAST);
        rh_wrap = (rhc == H_LAST);
        rv_wrap = (rvc == V_LAST);
        hs_act  = (32'(hc) >= HS_START) && (32'(hc) < HS_END);
        vs_act  = (32'(vc) >= VS_START) && (32'(vc) < VS_END);
        vis     = (32'(hc) < H_DISP) && (32'(vc) < V_DISP);
        rvis    = (32'(rhc) < H_DISP) && (32'(rvc) < V_DISP);
    end

    // Display and request rasters; each pair wraps on its own
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hc  <= '0;
            vc  <= '0;
            rhc <= RH_INIT;
            rvc <= '0;
        end else if (EN) begin
            hc  <= h_wrap ? '0 : hc + HW'(1);
            rhc <= rh_wrap ? '0 : rhc + HW'(1);
            if (h_wrap) begin
                vc <= v_wrap ? '0 : vc + VW'(1);
            end
            if (rh_wrap) begin
                rvc <= rv_wrap ? '0 : rvc + VW'(1);
            end
        end
    end

    // Wrap flags are delayed one CLK so the strobes line up with the
    // registered decode of the wrapped counter state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            line_wrap_q  <= 1'b0;
            frame_wrap_q <= 1'b0;
        end else begin
            line_wrap_q  <= EN && h_wrap;
            frame_wrap_q <= EN && h_wrap && v_wrap;
        end
    end

    // Registered output stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            VGA_HS      <= ~HS_ACT;
            VGA_VS      <= ~VS_ACT;
            VGA_BLANK   <= 1'b0;
            X           <= '0;
            Y           <= '0;
            REQ         <= 1'b0;
            REQ_X       <= '0;
            REQ_Y       <= '0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            VGA_HS      <= hs_act ? HS_ACT : ~HS_ACT;
            VGA_VS      <= vs_act ? VS_ACT : ~VS_ACT;
            VGA_BLANK   <= vis;
            X           <= vis ? hc : '0;
            Y           <= vis ? vc : '0;
            REQ         <= rvis;
            REQ_X       <= rvis ? rhc : '0;
            REQ_Y       <= rvis ? rvc : '0;
            LINE_START  <= line_wrap_q;
            FRAME_START <= frame_wrap_q;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two instances (tiny 7x5 raster with positive
// syncs and LOOKAHEAD=2, small 15x8 raster with negative syncs and
// LOOKAHEAD=0) checked each CLK against a tick-count reference model.
module tb_vga_timing_gen;

    typedef struct {
        int hs, vs, blank, x, y, req, rx, ry, ls, fs;
    } out_t;

    typedef struct {
        int hd, hf, hp, hb, vd, vf, vp, vb, hpol, vpol, la;
    } cfg_t;

    typedef struct {
        bit   en;
        bit   rst;
        out_t e;
    } vec_t;

    localparam cfg_t CA = '{4, 1, 1, 1, 2, 1, 1, 1, 1, 1, 2};
    localparam cfg_t CB = '{8, 2, 3, 2, 4, 1, 2, 1, 0, 0, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic       a_hs, a_vs, a_blank, a_sync, a_req, a_ls, a_fs;
    logic [2:0] a_x, a_rx;
    logic [2:0] a_y, a_ry;
    logic       b_hs, b_vs, b_blank, b_sync, b_req, b_ls, b_fs;
    logic [3:0] b_x, b_rx;
    logic [2:0] b_y, b_ry;

    int checks = 0;
    int errors = 0;

    out_t qa[$];
    out_t qb[$];

    int ta = 0, tb = 0;
    bit lwa = 0, fwa = 0, lwb = 0, fwb = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISP(4), .H_FP(1), .H_PULSE(1), .H_BP(1),
        .V_DISP(2), .V_FP(1), .V_PULSE(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .LOOKAHEAD(2)
    ) u_a (
        .CLK(clk), .RST(rst), .EN(en),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK(a_blank), .VGA_SYNC(a_sync),
        .X(a_x), .Y(a_y), .REQ(a_req), .REQ_X(a_rx), .REQ_Y(a_ry),
        .LINE_START(a_ls), .FRAME_START(a_fs)
    );

    vga_timing_gen #(
        .H_DISP(8), .H_FP(2), .H_PULSE(3), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_PULSE(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .LOOKAHEAD(0)
    ) u_b (
        .CLK(clk), .RST(rst), .EN(en),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK(b_blank), .VGA_SYNC(b_sync),
        .X(b_x), .Y(b_y), .REQ(b_req), .REQ_X(b_rx), .REQ_Y(b_ry),
        .LINE_START(b_ls), .FRAME_START(b_fs)
    );

    function automatic out_t reset_out(input cfg_t c);
        out_t o = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        o.hs = (c.hpol == 0) ? 1 : 0;
        o.vs = (c.vpol == 0) ? 1 : 0;
        return o;
    endfunction

    // Expected outputs for the raster position reached after t EN ticks
    function automatic out_t decode(input cfg_t c, input int t, input bit lw, input bit fw);
        out_t o;
        int ht, vt, p, q, hc, vc, rh, rv;
        bit vis, rvis;
        ht = c.hd + c.hf + c.hp + c.hb;
        vt = c.vd + c.vf + c.vp + c.vb;
        p  = t % (ht * vt);
        q  = (t + c.la) % (ht * vt);
        hc = p % ht;  vc = p / ht;
        rh = q % ht;  rv = q / ht;
        vis  = (hc < c.hd) && (vc < c.vd);
        rvis = (rh < c.hd) && (rv < c.vd);
        o.hs    = (hc >= c.hd + c.hf && hc < c.hd + c.hf + c.hp) ? c.hpol : 1 - c.hpol;
        o.vs    = (vc >= c.vd + c.vf && vc < c.vd + c.vf + c.vp) ? c.vpol : 1 - c.vpol;
        o.blank = vis ? 1 : 0;
        o.x     = vis ? hc : 0;
        o.y     = vis ? vc : 0;
        o.req   = rvis ? 1 : 0;
        o.rx    = rvis ? rh : 0;
        o.ry    = rvis ? rv : 0;
        o.ls    = lw ? 1 : 0;
        o.fs    = fw ? 1 : 0;
        return o;
    endfunction

    // One clock edge of the reference model
    task automatic model_edge(input cfg_t c, input bit e, input bit r,
                              inout int t, inout bit lw, inout bit fw, output out_t o);
        int ht, vt;
        ht = c.hd + c.hf + c.hp + c.hb;
        vt = c.vd + c.vf + c.vp + c.vb;
        if (r) begin
            o = reset_out(c);
            t = 0; lw = 0; fw = 0;
        end else begin
            o = decode(c, t, lw, fw);
            if (e) begin
                t  = t + 1;
                lw = (t % ht) == 0;
                fw = (t % (ht * vt)) == 0;
            end else begin
                lw = 0; fw = 0;
            end
        end
    endtask

    function automatic out_t cap_a();
        out_t o;
        o = '{int'(a_hs), int'(a_vs), int'(a_blank), int'(a_x), int'(a_y),
              int'(a_req), int'(a_rx), int'(a_ry), int'(a_ls), int'(a_fs)};
        return o;
    endfunction

    function automatic out_t cap_b();
        out_t o;
        o = '{int'(b_hs), int'(b_vs), int'(b_blank), int'(b_x), int'(b_y),
              int'(b_req), int'(b_rx), int'(b_ry), int'(b_ls), int'(b_fs)};
        return o;
    endfunction

    task automatic chk1(input string tag, input string f, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s @%0t: got %0d expected %0d", tag, f, $time, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input out_t a, input out_t e);
        chk1(tag, "hs", a.hs, e.hs);
        chk1(tag, "vs", a.vs, e.vs);
        chk1(tag, "blank", a.blank, e.blank);
        chk1(tag, "x", a.x, e.x);
        chk1(tag, "y", a.y, e.y);
        chk1(tag, "req", a.req, e.req);
        chk1(tag, "req_x", a.rx, e.rx);
        chk1(tag, "req_y", a.ry, e.ry);
        chk1(tag, "line_start", a.ls, e.ls);
        chk1(tag, "frame_start", a.fs, e.fs);
    endtask

    // Drive one CLK: push model expectations, take the edge, compare
    task automatic step(input bit e, input bit r, output out_t got_a);
        out_t ea, eb, xa, xb;
        model_edge(CA, e, r, ta, lwa, fwa, ea);
        model_edge(CB, e, r, tb, lwb, fwb, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        en  = e;
        rst = r;
        @(posedge clk);
        @(negedge clk);
        xa = qa.pop_front();
        xb = qb.pop_front();
        got_a = cap_a();
        cmp("a", got_a, xa);
        cmp("b", cap_b(), xb);
        chk1("a", "sync", int'(a_sync), 0);
        chk1("b", "sync", int'(b_sync), 0);
    endtask

    initial begin
        vec_t vt[12];
        out_t g;

        // Hand-derived start of the tiny raster: reset, release, EN stalls,
        // request window leading display by 2, first line wrap strobe
        vt[0]  = '{1'b1, 1'b1, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[1]  = '{1'b1, 1'b0, '{0, 0, 1, 0, 0, 1, 2, 0, 0, 0}};
        vt[2]  = '{1'b0, 1'b0, '{0, 0, 1, 1, 0, 1, 3, 0, 0, 0}};
        vt[3]  = '{1'b0, 1'b0, '{0, 0, 1, 1, 0, 1, 3, 0, 0, 0}};
        vt[4]  = '{1'b1, 1'b0, '{0, 0, 1, 1, 0, 1, 3, 0, 0, 0}};
        vt[5]  = '{1'b1, 1'b0, '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0}};
        vt[6]  = '{1'b1, 1'b0, '{0, 0, 1, 3, 0, 0, 0, 0, 0, 0}};
        vt[7]  = '{1'b1, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[8]  = '{1'b1, 1'b0, '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0}};
        vt[9]  = '{1'b1, 1'b0, '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0}};
        vt[10] = '{1'b1, 1'b0, '{0, 0, 1, 0, 1, 1, 2, 1, 1, 0}};
        vt[11] = '{1'b1, 1'b0, '{0, 0, 1, 1, 1, 1, 3, 1, 0, 0}};

        for (int i = 0; i < 12; i++) begin
            step(vt[i].en, vt[i].rst, g);
            cmp($sformatf("vec%0d", i), g, vt[i].e);
        end

        // EN every second CLK
        for (int i = 0; i < 600; i++) step(i % 2 == 0, 1'b0, g);

        // Random EN density
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 9) < 7, 1'b0, g);

        // Advance into the middle of a line, then stall EN for 50 CLK
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, g);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, g);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, g);

        // Asynchronous reset mid-frame: outputs drop before any clock edge
        rst = 1'b1;
        #1;
        cmp("async_a", cap_a(), reset_out(CA));
        cmp("async_b", cap_b(), reset_out(CB));
        step(1'b1, 1'b1, g);
        step(1'b0, 1'b1, g);

        // Release and run several full frames with EN held high
        for (int i = 0; i < 400; i++) step(1'b1, 1'b0, g);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
